// File: rtl/latch_bank_writer.sv
// latch_bank_writer: write-side sequencer for a bank of en/d storage latches.
// Accepts one (address, data) request on a valid/ready handshake. It then drives
// the shared data bus and a one-hot enable in three phases: setup, strobe, hold.
// This keeps lat_d stable whenever any enable is high.
// Optional feature macro: LATCH_BANK_SHADOW_EN. It adds a readable shadow copy
// of every cell, with the ports rd_addr and rd_data.
module latch_bank_writer #(
    parameter int DATA_W    = 8,
    parameter int NUM_CELLS = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    localparam int ADDR_W   = $clog2(NUM_CELLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_data,
    output logic [DATA_W-1:0]    lat_d,
    output logic [NUM_CELLS-1:0] lat_en,
    output logic                 busy,
    output logic                 done,
`ifdef LATCH_BANK_SHADOW_EN
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]    rd_data,
`endif
    output logic                 err
);

    localparam int MAX_CYC_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC    = (MAX_CYC_SP > HOLD_CYC) ? MAX_CYC_SP : HOLD_CYC;
    localparam int CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]  SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W:0]   CELL_LIMIT = (ADDR_W + 1)'(NUM_CELLS);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [ADDR_W-1:0]    addr_q;
    logic                 accept;
    logic                 addr_ok;
    logic [NUM_CELLS-1:0] en_onehot;
    logic [NUM_CELLS-1:0] en_next;
    logic                 done_next;
    logic                 err_next;

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign addr_ok   = ({1'b0, req_addr} < CELL_LIMIT);
    assign en_onehot = {{(NUM_CELLS-1){1'b0}}, 1'b1} << addr_q;

    // State register and phase down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: each phase reloads the counter on entry and leaves at zero
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (accept && addr_ok) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_next = STROBE;
                    cnt_next   = PULSE_LOAD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode: next values of the registered strobe and status pulses
    always_comb begin
        en_next   = (state_next == STROBE) ? en_onehot : '0;
        done_next = (state == HOLD) && (state_next == IDLE);
        err_next  = accept && !addr_ok;
    end

    // Output registers; lat_d and the target address change only when a request is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_en <= '0;
            lat_d  <= '0;
            addr_q <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            lat_en <= en_next;
            done   <= done_next;
            err    <= err_next;
            if (accept && addr_ok) begin
                lat_d  <= req_data;
                addr_q <= req_addr;
            end
        end
    end

`ifdef LATCH_BANK_SHADOW_EN
    logic [DATA_W-1:0] shadow [NUM_CELLS];

    // Shadow copy records the stored value when the strobe for that cell ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                shadow[i] <= '0;
            end
        end else if ((state == STROBE) && (state_next == HOLD)) begin
            shadow[addr_q] <= lat_d;
        end
    end

    // Combinational shadow read, zero for addresses past the last cell
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < CELL_LIMIT) begin
            rd_data = shadow[rd_addr];
        end
    end
`endif

endmodule

// File: doc/latch_bank_writer.md
Name: latch_bank_writer

Overview:
- Write-side sequencer for a bank of enable-gated, level-sensitive storage cells (en/d style latches).
- Accepts one (address, data) write request over a valid/ready handshake.
- Drives shared data bus lat_d and a one-hot enable lat_en with guaranteed setup, pulse-width and hold spacing, so d is never changing while any en is high.
- Sits between a register-programming master and the latch bank.

Parameters:
- DATA_W, 8, width of data word and lat_d.
- NUM_CELLS, 4, number of storage cells (width of lat_en); >=2.
- SETUP_CYC, 1, cycles lat_d is stable before enable rises; >=1.
- PULSE_CYC, 2, cycles enable is held high; >=1.
- HOLD_CYC, 1, cycles lat_d is held after enable falls; >=1.
- ADDR_W, $clog2(NUM_CELLS), request address width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  write request valid.
- req_ready  output  1  block can accept a request.
- req_addr  input  ADDR_W  target cell index.
- req_data  input  DATA_W  value to store.
- lat_d  output  DATA_W  shared data to cells.
- lat_en  output  NUM_CELLS  one-hot cell enable.
- busy  output  1  sequence in progress (state != IDLE).
- done  output  1  one-cycle pulse on sequence completion.
- err  output  1  one-cycle pulse, rejected out-of-range address.

Behaviour:
- Reset (async, active-high): state IDLE; lat_d=0, lat_en=0, done=0, err=0, busy=0. req_ready=1 once rst deasserts. Any mid-sequence reset drops lat_en to 0 immediately, without waiting for a clock edge.
- States: IDLE, SETUP, STROBE, HOLD. One down-counter, reloaded on each state entry.
- Handshake and ready:
  - req_ready=1 only in IDLE.
  - Accept = req_valid && req_ready at a rising edge. Addr and data are registered on accept; later input changes are ignored.
- Valid address (req_addr < NUM_CELLS):
  - IDLE -> SETUP. lat_d = captured data, lat_en=0, for SETUP_CYC cycles.
  - SETUP -> STROBE. lat_en = 1<<addr for PULSE_CYC cycles; lat_d unchanged.
  - STROBE -> HOLD. lat_en=0, lat_d unchanged, for HOLD_CYC cycles.
  - HOLD -> IDLE. done=1 for exactly the first IDLE cycle.
- Latency: accept edge to done cycle = SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
- Invalid address (req_addr >= NUM_CELLS, possible only for non-power-of-two NUM_CELLS): stay IDLE, err=1 for the next cycle, lat_en and lat_d unchanged, no done.
- lat_d holds its last value in IDLE; it changes only on entry to SETUP.
- lat_en is registered, glitch-free, at most one bit high, never high outside STROBE.
- Back-to-back: a request may be accepted in the done cycle. Minimum lat_en-low gap between strobes = HOLD_CYC+1+SETUP_CYC cycles.
- busy = (state != IDLE). done and err are never high together.

Optional Feature:
- Macro: LATCH_BANK_SHADOW_EN.
- Defined:
  - Adds ports rd_addr (input, ADDR_W) and rd_data (output, DATA_W).
  - Internal flop shadow array updated with the captured data at the STROBE->HOLD transition.
  - rd_data = shadow[rd_addr], combinational; 0 for out-of-range rd_addr.
  - Shadow entries reset to 0.
- Undefined: those ports and the shadow storage are absent; all other behaviour identical.

Test Plan (defaults unless stated; accept edge = cycle 0):
- Reset: assert rst mid-clock -> lat_en=0, lat_d=0, done=0, err=0, busy=0 immediately; req_ready=1 after release.
- Single write, addr=2, data=0xA5:
  - cycle 1: lat_d=0xA5, lat_en=0.
  - cycles 2-3: lat_en=4'b0100.
  - cycle 4: lat_en=0, lat_d=0xA5.
  - cycle 5: done=1, req_ready=1, busy=0.
- Back-to-back: second request addr=1, data=0x3C held valid, accepted at cycle 5 -> lat_d=0x3C at cycle 6, lat_en=4'b0010 cycles 7-8. lat_d unchanged while lat_en!=0; lat_en=0 cycles 4-6.
- Bad address: NUM_CELLS=3, addr=3 -> err=1 at cycle 1, lat_en stays 0, no done, req_ready stays 1.
- Reset mid-strobe: rst asserted during cycle 2 of the single-write case -> lat_en=0 before the next edge, lat_d=0, state IDLE after release, no done.
- Shadow (LATCH_BANK_SHADOW_EN): after the single write -> rd_addr=2 gives rd_data=0xA5; rd_addr=0 gives 0x00.
